// File: rtl/ahb_mem_fill.sv
// AHB-lite master that fills a memory range with a (optionally incrementing) pattern,
// or reads the range back and counts words that differ from that pattern.
module ahb_mem_fill #(
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32,
  parameter int W_COUNT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode_check,
  input  logic               incr,
  input  logic [W_ADDR-1:0]  base_addr,
  input  logic [W_COUNT-1:0] count,
  input  logic [31:0]        pattern,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [W_COUNT-1:0] mismatch_count,
  output logic [W_ADDR-1:0]  first_mismatch_addr,
  output logic [W_ADDR-1:0]  ahblm_haddr,
  output logic               ahblm_hwrite,
  output logic [1:0]         ahblm_htrans,
  output logic [2:0]         ahblm_hsize,
  output logic [2:0]         ahblm_hburst,
  output logic [3:0]         ahblm_hprot,
  output logic               ahblm_hmastlock,
  output logic [W_DATA-1:0]  ahblm_hwdata,
  input  logic               ahblm_hready,
  input  logic               ahblm_hresp,
  input  logic [W_DATA-1:0]  ahblm_hrdata
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic               incr_q, incr_d;
  logic               hwrite_q, hwrite_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [W_COUNT-1:0] mismatch_count_q, mismatch_count_d;
  logic [W_ADDR-1:0]  first_mismatch_addr_q, first_mismatch_addr_d;
  logic [W_COUNT-1:0] beats_left_q, beats_left_d;
  logic [W_ADDR-1:0]  ap_addr_q, ap_addr_d;
  logic [31:0]        ap_data_q, ap_data_d;
  logic               dp_vld_q, dp_vld_d;
  logic [W_ADDR-1:0]  dp_addr_q, dp_addr_d;
  logic [31:0]        dp_data_q, dp_data_d;
  logic [W_DATA-1:0]  hwdata_q, hwdata_d;

  always_comb begin
    state_d               = state_q;
    mode_d                = mode_q;
    incr_d                = incr_q;
    hwrite_d              = hwrite_q;
    busy_d                = busy_q;
    done_d                = done_q;
    err_d                 = err_q;
    mismatch_count_d      = mismatch_count_q;
    first_mismatch_addr_d = first_mismatch_addr_q;
    beats_left_d          = beats_left_q;
    ap_addr_d             = ap_addr_q;
    ap_data_d             = ap_data_q;
    dp_vld_d              = dp_vld_q;
    dp_addr_d             = dp_addr_q;
    dp_data_d             = dp_data_q;
    hwdata_d              = hwdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d       = mode_check;
          incr_d       = incr;
          hwrite_d     = !mode_check;
          ap_addr_d    = base_addr & ~W_ADDR'(3);
          ap_data_d    = pattern;
          beats_left_d = count;
          dp_vld_d     = 1'b0;
          if (count != '0) begin
            state_d               = S_RUN;
            busy_d                = 1'b1;
            err_d                 = 1'b0;
            mismatch_count_d      = '0;
            first_mismatch_addr_d = '0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_RUN, S_DRAIN: begin
        if (ahblm_hready) begin
          if (dp_vld_q && ahblm_hresp) begin
            // Second cycle of an error response: abandon the remaining beats.
            err_d    = 1'b1;
            dp_vld_d = 1'b0;
            state_d  = S_DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            if (dp_vld_q && mode_q && (ahblm_hrdata != dp_data_q)) begin
              if (mismatch_count_q == '0) first_mismatch_addr_d = dp_addr_q;
              if (mismatch_count_q != '1) mismatch_count_d = mismatch_count_q + W_COUNT'(1);
            end
            if (state_q == S_RUN) begin
              dp_vld_d  = 1'b1;
              dp_addr_d = ap_addr_q;
              dp_data_d = ap_data_q;
              hwdata_d  = mode_q ? '0 : ap_data_q;
              if (beats_left_q == W_COUNT'(1)) begin
                state_d = S_DRAIN;
              end else begin
                ap_addr_d    = ap_addr_q + W_ADDR'(4);
                ap_data_d    = ap_data_q + {31'd0, incr_q};
                beats_left_d = beats_left_q - W_COUNT'(1);
              end
            end else begin
              dp_vld_d = 1'b0;
              state_d  = S_DONE;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q               <= S_IDLE;
      mode_q                <= 1'b0;
      incr_q                <= 1'b0;
      hwrite_q              <= 1'b0;
      busy_q                <= 1'b0;
      done_q                <= 1'b0;
      err_q                 <= 1'b0;
      mismatch_count_q      <= '0;
      first_mismatch_addr_q <= '0;
      beats_left_q          <= '0;
      ap_addr_q             <= '0;
      ap_data_q             <= '0;
      dp_vld_q              <= 1'b0;
      dp_addr_q             <= '0;
      dp_data_q             <= '0;
      hwdata_q              <= '0;
    end else begin
      state_q               <= state_d;
      mode_q                <= mode_d;
      incr_q                <= incr_d;
      hwrite_q              <= hwrite_d;
      busy_q                <= busy_d;
      done_q                <= done_d;
      err_q                 <= err_d;
      mismatch_count_q      <= mismatch_count_d;
      first_mismatch_addr_q <= first_mismatch_addr_d;
      beats_left_q          <= beats_left_d;
      ap_addr_q             <= ap_addr_d;
      ap_data_q             <= ap_data_d;
      dp_vld_q              <= dp_vld_d;
      dp_addr_q             <= dp_addr_d;
      dp_data_q             <= dp_data_d;
      hwdata_q              <= hwdata_d;
    end
  end

  // htrans looks at hresp directly so a pending address phase is cancelled in the
  // first error cycle, before the slave can accept it.
  assign ahblm_htrans        = (state_q == S_RUN && !ahblm_hresp) ? 2'b10 : 2'b00;
  assign ahblm_haddr         = ap_addr_q;
  assign ahblm_hwrite        = hwrite_q;
  assign ahblm_hwdata        = hwdata_q;
  assign ahblm_hsize         = 3'b010;
  assign ahblm_hburst        = 3'b000;
  assign ahblm_hprot         = 4'b0011;
  assign ahblm_hmastlock     = 1'b0;
  assign busy                = busy_q;
  assign done                = done_q;
  assign err                 = err_q;
  assign mismatch_count      = mismatch_count_q;
  assign first_mismatch_addr = first_mismatch_addr_q;

endmodule

// File: doc/ahb_mem_fill.md
AHB_MEM_FILL -- requirements
Module: ahb_mem_fill

Interface
REQ-001 The block SHALL have these parameters:
- W_ADDR, default 32, AHB address width.
- W_DATA, default 32, AHB data width; only 32 is supported.
- W_COUNT, default 16, beat-count width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request to begin an operation.
- mode_check  in  1  0 = fill (write), 1 = check (read and compare).
- incr  in  1  1 = pattern increments by 1 per beat.
- base_addr  in  W_ADDR  start byte address; bits [1:0] are ignored and treated as 0.
- count  in  W_COUNT  number of 32-bit beats.
- pattern  in  32  first data word.
- busy  out  1  an operation is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  the last operation ended on an AHB error response.
- mismatch_count  out  W_COUNT  number of check-mode compare failures.
- first_mismatch_addr  out  W_ADDR  byte address of the first compare failure.
- AHB master outputs, with widths per AHB-lite: ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst, ahblm_hprot, ahblm_hmastlock, ahblm_hwdata.
- AHB master inputs: ahblm_hready, ahblm_hresp, ahblm_hrdata.

REQ-003 The block SHALL use one clock, clk, with asynchronous active-low reset rst_n.

Function
REQ-004 The block SHALL hold an FSM with states IDLE, RUN, DRAIN, DONE.
REQ-005 In IDLE, when start=1, the block SHALL capture mode_check, incr, base_addr, count and pattern; later changes to these inputs SHALL have no effect until the next start.
REQ-006 start while busy=1 SHALL be ignored.
REQ-007 Transitions out of IDLE on start:
- count!=0: go to RUN, clear err, mismatch_count and first_mismatch_addr.
- count==0: go to DONE with no bus traffic.
REQ-008 busy SHALL be 1 in RUN and DRAIN, and 0 otherwise.
REQ-009 The first address phase SHALL be driven in the cycle after start is sampled.
REQ-010 Every beat SHALL be issued as:
- htrans=NONSEQ(2'b10), hsize=3'b010, hburst=3'b000, hprot=4'b0011, hmastlock=0.
- hwrite = !mode_check.
REQ-011 Beat i (0-based) SHALL have address base + 4*i, wrapping modulo 2^W_ADDR.
REQ-012 Beat i SHALL have expected data pattern + (incr ? i : 0), modulo 2^32.
REQ-013 In RUN, one beat's address phase SHALL be issued per cycle while ahblm_hready=1, so address phases are back-to-back with no idle cycles at zero wait states.
REQ-014 While ahblm_hready=0, haddr, htrans and all control outputs SHALL hold stable, and so SHALL hwdata.
REQ-015 In fill mode, ahblm_hwdata SHALL carry beat i's data throughout beat i's data phase.
REQ-016 In check mode, ahblm_hwdata SHALL be 0.
REQ-017 In check mode, ahblm_hrdata SHALL be compared to the expected data on the cycle beat i's data phase completes (hready=1, hresp=0).
REQ-018 On a compare failure, mismatch_count SHALL increment and saturate at all-ones.
REQ-019 On the first failure of an operation, first_mismatch_addr SHALL be loaded with that beat's address.
REQ-020 After the last beat's address phase is accepted, the FSM SHALL go to DRAIN and drive htrans=IDLE(2'b00).
REQ-021 From DRAIN, the FSM SHALL go to DONE when the last data phase completes.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 AHB error handling:
- On ahblm_hresp=1 with ahblm_hready=0 (first error cycle), htrans SHALL be IDLE in that same cycle and no further beats SHALL be issued.
- On the following cycle (hresp=1, hready=1), err SHALL be set and the FSM SHALL go to DONE.
- A beat that receives an error response SHALL not be compared.
REQ-024 Outside RUN, htrans SHALL be IDLE; in RUN it SHALL be NONSEQ.
REQ-025 The beat counter and address/data counters SHALL be W_COUNT, W_ADDR and 32 bits respectively.
REQ-026 count = 2^W_COUNT-1 SHALL complete without counter overflow.

Reset
REQ-027 Asynchronous assertion of rst_n SHALL immediately force:
- FSM to IDLE.
- htrans=IDLE, busy=0, done=0, err=0.
- mismatch_count=0, first_mismatch_addr=0, haddr=0, hwdata=0, hwrite=0.
REQ-028 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-029 After reset deassertion, the block SHALL accept start on the first clock edge.

Verification
REQ-030 Fill, zero wait: base 0x100, count 4, pattern 0xA5A50000, incr=1, start at cycle 0 ->
- NONSEQ writes to 0x100, 0x104, 0x108, 0x10C in cycles 1-4.
- hwdata 0xA5A50000..0xA5A50003 in cycles 2-5.
- done=1 in cycle 6; err=0.
REQ-031 Check mode: count 3, pattern 0x12345678, incr=0, base 0x200; slave returns 0x12345678, 0x0, 0x12345678 -> mismatch_count=1, first_mismatch_addr=0x204.
REQ-032 Wait states: as REQ-030 with hready=0 for 2 cycles during beat 1's data phase -> beat-2 address and beat-1 hwdata held stable; done in cycle 8.
REQ-033 Error: slave gives a two-cycle hresp on beat 1 of 4 -> htrans=IDLE from the first error cycle; no beat-2 or beat-3 address phases; err=1; done pulse.
REQ-034 count=0 start -> no NONSEQ issued; done=1 in cycle 1; busy stays 0.
REQ-035 Reset mid-run: rst_n low during beat 2 of 8 -> htrans=IDLE and busy=0 immediately; no done; a new start after release runs normally.
